// File: rtl/regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regbank_pkg
// Description : Shared types and constants for the configuration register
//               bank arbiter: arbiter state encoding, register address map
//               and the default read-only address mask.
// Revision    : 1.0 - initial release
// ============================================================================
package regbank_pkg;

    // Arbiter sequence: one grant walks IDLE -> ACCESS -> RESP -> IDLE
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    // Function generator registers
    localparam logic [3:0] FG_CON  = 4'd0;
    localparam logic [3:0] FG_CLK  = 4'd1;
    localparam logic [3:0] FG_SIG  = 4'd2;
    localparam logic [3:0] FG_STEP = 4'd3;
    localparam logic [3:0] FG_AMP  = 4'd4;
    localparam logic [3:0] FG_OFF  = 4'd5;
    localparam logic [3:0] FG_PH   = 4'd6;
    localparam logic [3:0] FG_DC   = 4'd7;
    localparam logic [3:0] FG_OUT  = 4'd8;

    // PWM registers
    localparam logic [3:0] PWM_CLK = 4'd9;
    localparam logic [3:0] PWM_TMR = 4'd10;
    localparam logic [3:0] PWM_PR  = 4'd11;
    localparam logic [3:0] PWM_DC  = 4'd12;
    localparam logic [3:0] PWM_PH  = 4'd13;
    localparam logic [3:0] PWM_CON = 4'd14;

    // Status registers (FG_OUT, PWM_TMR) are driven by hardware, not masters
    localparam logic [15:0] DEFAULT_RO_MASK = 16'h0500;

endpackage : regbank_pkg
`default_nettype wire

// File: rtl/regbank_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the first set
//               request bit at or after the pointer, wrapping at NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_winner
);

    // Scan offsets from farthest to nearest so the nearest set bit wins last
    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(i_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (i_req[idx]) begin
                o_valid  = 1'b1;
                o_winner = IDX_W'(idx);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/regbank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regbank_arbiter
// Description : Round-robin arbiter sharing the 16 x 12-bit configuration
//               register bank between NUM_REQ bus masters. Each grant runs a
//               fixed IDLE -> ACCESS -> RESP sequence; writes to read-only
//               status addresses are dropped and reported through err.
// Revision    : 1.0 - initial release
// ============================================================================
module regbank_arbiter
    import regbank_pkg::*;
#(
    parameter int                        NUM_REQ = 2,
    parameter int                        ADDR_W  = 4,
    parameter int                        DATA_W  = 12,
    parameter logic [(1<<ADDR_W)-1:0]    RO_MASK = DEFAULT_RO_MASK
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]           ack,
    output logic [DATA_W-1:0]            rdata,
    output logic                         err,
    output logic                         busy,
    output logic                         rf_write_en,
    output logic [ADDR_W-1:0]            rf_addr,
    output logic [DATA_W-1:0]            rf_data_in,
    input  logic [DATA_W-1:0]            rf_data_out
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t           r_state;
    arb_state_t           w_state_next;
    logic [c_IDX_W-1:0]   r_ptr;
    logic [c_IDX_W-1:0]   r_win;
    logic                 r_we;

    logic                 w_pick_valid;
    logic [c_IDX_W-1:0]   w_pick_idx;
    logic                 w_sel_we;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic                 w_load;
    logic                 w_finish;
    logic                 w_release;
    logic [NUM_REQ-1:0]   w_ack_onehot;
    logic [c_IDX_W-1:0]   w_ptr_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_valid  (w_pick_valid),
        .o_winner (w_pick_idx)
    );

    // Route the winning master's request fields
    assign w_sel_we    = req_we[w_pick_idx];
    assign w_sel_addr  = req_addr[w_pick_idx*ADDR_W +: ADDR_W];
    assign w_sel_wdata = req_wdata[w_pick_idx*DATA_W +: DATA_W];

    // Next state and per-state strobes for the output registers
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_finish     = 1'b0;
        w_release    = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_load       = 1'b1;
                    w_state_next = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                w_finish     = 1'b1;
                w_state_next = ARB_RESP;
            end
            ARB_RESP: begin
                w_release    = 1'b1;
                w_state_next = ARB_IDLE;
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    // One-hot acknowledge for the latched winner and the following pointer
    always_comb begin
        w_ack_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_ack_onehot[k] = (r_win == c_IDX_W'(k));
        end
        w_ptr_next = (r_win == c_IDX_W'(NUM_REQ - 1)) ? '0 : r_win + 1'b1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Transaction latches and registered outputs; rf_addr/rf_data_in hold
    // outside ACCESS, and the write strobe lives only for the ACCESS cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= '0;
            r_win       <= '0;
            r_we        <= 1'b0;
            ack         <= '0;
            rdata       <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
            rf_write_en <= 1'b0;
            rf_addr     <= '1;
            rf_data_in  <= '0;
        end else begin
            ack         <= '0;
            err         <= 1'b0;
            rf_write_en <= 1'b0;
            if (w_load) begin
                r_win       <= w_pick_idx;
                r_we        <= w_sel_we;
                rf_addr     <= w_sel_addr;
                rf_data_in  <= w_sel_wdata;
                rf_write_en <= w_sel_we & ~RO_MASK[w_sel_addr];
                busy        <= 1'b1;
            end
            if (w_finish) begin
                rdata <= rf_data_out;
                ack   <= w_ack_onehot;
                err   <= r_we & RO_MASK[rf_addr];
            end
            if (w_release) begin
                busy  <= 1'b0;
                r_ptr <= w_ptr_next;
            end
        end
    end

endmodule : regbank_arbiter
`default_nettype wire

// File: doc/regbank_arbiter.md
# regbank_arbiter

- Shares the single 16-entry × 12-bit configuration register bank (function generator and PWM control and status registers) between NUM_REQ bus masters, for example the UART command FSM and an on-chip sequencer.
- Arbitrates round-robin and runs one read or write per grant through a fixed 3-state sequence.
- Drops writes to read-only status addresses and flags them as errors.
- Returns read data and a one-cycle acknowledge to the winning master.

## Interface
Parameters:
- NUM_REQ, 2, number of requesting masters (2..4)
- ADDR_W, 4, register address width
- DATA_W, 12, register data width
- RO_MASK, 16'h0500, bit i set means address i is read-only (8 = fg_out, 10 = pwm_tmr)

Ports:
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- req  in  NUM_REQ  per-master transaction request, level
- req_we  in  NUM_REQ  per-master write (1) / read (0)
- req_addr  in  NUM_REQ*ADDR_W  per-master address, master i at slice [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  per-master write data, same packing
- ack  out  NUM_REQ  one-cycle completion pulse to the granted master
- rdata  out  DATA_W  read data, valid when any ack bit is high
- err  out  1  write to a read-only address, valid with ack
- busy  out  1  high in ACCESS and RESP
- rf_write_en  out  1  register bank write strobe
- rf_addr  out  ADDR_W  register bank address
- rf_data_in  out  DATA_W  register bank write data
- rf_data_out  in  DATA_W  register bank read data, combinational from rf_addr

## Operation
- State machine states: IDLE, ACCESS, RESP.
- **IDLE**
  - If any req bit is set, pick the winner as the first set bit at or after rr_ptr, wrapping.
  - Latch the winner index, req_we, req_addr and req_wdata.
  - Go to ACCESS.
  - If no req bit is set, stay in IDLE.
- **ACCESS**
  - rf_addr = latched address.
  - rf_data_in = latched wdata.
  - rf_write_en = latched we & ~RO_MASK[addr].
  - Capture rf_data_out into rdata at the end of the cycle; this happens for writes too.
  - Go to RESP.
- **RESP**
  - ack[winner] = 1.
  - err = latched we & RO_MASK[addr].
  - rr_ptr = (winner + 1) mod NUM_REQ.
  - Go to IDLE.
- Read-only write: rf_write_en stays 0, ack still pulses, err = 1.
- Reads of read-only addresses are normal reads with err = 0.
- Masters hold req/we/addr/wdata stable until ack.
  - If req drops mid-transaction, the latched transaction still completes and ack still pulses.
  - If req is still high in the cycle after ack, it is a new request.
- Fairness: a continuously requesting master waits at most NUM_REQ−1 transactions.
- All outputs are registered.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0
  - ack 0, rdata 0, err 0, busy 0
  - rf_write_en 0, rf_addr 4'hF, rf_data_in 0
- Latency: req sampled high at edge t, ACCESS during cycle t+1, ack during cycle t+2.
- Throughput: one transaction per 3 cycles; IDLE lasts at least 1 cycle between transactions.
- ack, err and busy deassert the cycle after RESP.
- rf_write_en is high for exactly one cycle per accepted write.
- rdata holds its value until the next RESP.
- Simultaneous requests: the rr_ptr order decides. After reset, master 0 wins a tie.
- Wrap-around: rr_ptr goes from NUM_REQ−1 to 0.
- Reset asserted in ACCESS or RESP:
  - On that edge: state goes to IDLE, all outputs take reset values, and no ack is issued.
  - A write strobe already driven during that cycle is not retracted. The register bank resets on the same edge.
- Outside ACCESS, rf_write_en = 0 and rf_addr/rf_data_in hold their last values.

## Structure
- Package regbank_pkg holds:
  - state enum arb_state_t {ARB_IDLE, ARB_ACCESS, ARB_RESP}
  - register address localparams: FG_CON=0, FG_CLK=1, FG_SIG=2, FG_STEP=3, FG_AMP=4, FG_OFF=5, FG_PH=6, FG_DC=7, FG_OUT=8, PWM_CLK=9, PWM_TMR=10, PWM_PR=11, PWM_DC=12, PWM_PH=13, PWM_CON=14
  - default RO mask constant
- One sub-module, rr_pick: purely combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: valid and winner index.
  - Instantiated once.

## Test plan
- Master 0 writes addr 4'h2, data 12'h5A5 → rf_write_en high one cycle with rf_addr=2 and rf_data_in=12'h5A5. ack[0] pulses 2 cycles after req is sampled, err=0.
- Master 1 reads addr 4'h2 after the write above, with the bank model returning stored data → rdata=12'h5A5 with ack[1]; rf_write_en stays 0.
- Master 0 writes addr 4'h8, data 12'hFFF → rf_write_en never asserts; ack[0] pulses with err=1; a following read of addr 8 returns the bank value with err=0.
- req=2'b11 held for 4 transactions after reset → grant order 0,1,0,1, each ack 3 cycles apart.
- Reset asserted during ACCESS of a read → no ack; all outputs at reset values next cycle; rf_addr=4'hF; the next transaction completes normally.
- req[1] drops during ACCESS → ack[1] still pulses once; no new transaction starts.
